// File: rtl/win_checker.sv
// Five-in-a-row detector for a 16x16 two-player board.
// Scans one anchor cell per cycle over a snapshot taken at start.
module win_checker (
    input  logic         Clck,
    input  logic         Reset,
    input  logic [511:0] board,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic [1:0]   winner,
    output logic [3:0]   win_x,
    output logic [3:0]   win_y,
    output logic [1:0]   win_dir
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [511:0] snap;
    logic [7:0]   anchor;
    logic         empty_seen;

    logic [3:0]   ax;
    logic [3:0]   ay;
    logic [1:0]   cur;
    logic         cur_player;
    logic         cur_empty;
    logic [3:0]   hit;
    logic         any_hit;
    logic [1:0]   hit_dir;

    function automatic logic [1:0] cell_at(
        input logic [511:0] b,
        input logic [3:0]   x,
        input logic [3:0]   y
    );
        return b[{y, x, 1'b0} +: 2];
    endfunction

    assign ax = anchor[3:0];
    assign ay = anchor[7:4];

    // Bounds gate each direction, so wrapped coordinates below never matter.
    always_comb begin
        cur        = cell_at(snap, ax, ay);
        cur_player = (cur == 2'b01) || (cur == 2'b10);
        cur_empty  = !cur_player;
        hit[0]     = cur_player && (ax <= 4'd11);
        hit[1]     = cur_player && (ay <= 4'd11);
        hit[2]     = cur_player && (ax <= 4'd11) && (ay <= 4'd11);
        hit[3]     = cur_player && (ax >= 4'd4) && (ay <= 4'd11);
        for (int i = 1; i < 5; i++) begin
            if (cell_at(snap, ax + 4'(i), ay) != cur)
                hit[0] = 1'b0;
            if (cell_at(snap, ax, ay + 4'(i)) != cur)
                hit[1] = 1'b0;
            if (cell_at(snap, ax + 4'(i), ay + 4'(i)) != cur)
                hit[2] = 1'b0;
            if (cell_at(snap, ax - 4'(i), ay + 4'(i)) != cur)
                hit[3] = 1'b0;
        end
    end

    assign any_hit = |hit;

    always_comb begin
        if (hit[0])
            hit_dir = 2'd0;
        else if (hit[1])
            hit_dir = 2'd1;
        else if (hit[2])
            hit_dir = 2'd2;
        else
            hit_dir = 2'd3;
    end

    always_ff @(posedge Clck) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = SCAN;
            SCAN: begin
                if (any_hit || (anchor == 8'hFF))
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SCAN);
        done = (state == DONE);
    end

    always_ff @(posedge Clck) begin
        if (Reset) begin
            anchor     <= 8'd0;
            winner     <= 2'b00;
            win_x      <= 4'd0;
            win_y      <= 4'd0;
            win_dir    <= 2'd0;
            empty_seen <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        snap       <= board;
                        anchor     <= 8'd0;
                        winner     <= 2'b00;
                        win_x      <= 4'd0;
                        win_y      <= 4'd0;
                        win_dir    <= 2'd0;
                        empty_seen <= 1'b0;
                    end
                end
                SCAN: begin
                    anchor <= anchor + 8'd1;
                    if (cur_empty)
                        empty_seen <= 1'b1;
                    if (any_hit) begin
                        winner  <= cur;
                        win_x   <= ax;
                        win_y   <= ay;
                        win_dir <= hit_dir;
                    end else if (anchor == 8'hFF) begin
                        winner <= (empty_seen || cur_empty)
                                  ? 2'b00 : 2'b11;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/win_checker.md
WIN_CHECKER -- requirements
Module: win_checker

Interface
REQ-001 The block SHALL have no parameters; board geometry is fixed at 16x16 cells, 2 bits per cell, and the win run length is fixed at 5.
REQ-002 The block SHALL have port Clck, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port board, input, 512 bits: the game board, where cell (x,y) occupies bits [x*2 + y*32 +: 2].
REQ-005 The board cell encoding SHALL be 00 empty, 01 player 1, 10 player 2, 11 invalid (treated as empty).
REQ-006 The block SHALL have port start, input, 1 bit: scan request, sampled only in IDLE.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in SCAN.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking valid results.
REQ-009 The block SHALL have port winner, output, 2 bits: 00 none, 01 player 1, 10 player 2, 11 draw (board full).
REQ-010 The block SHALL have ports win_x and win_y, output, 4 bits each: the anchor cell of the winning run.
REQ-011 The block SHALL have port win_dir, output, 2 bits: 00 E (+x), 01 S (+y), 10 SE (+x,+y), 11 SW (-x,+y).

Function
REQ-012 The state machine SHALL have three states: IDLE, SCAN and DONE.
REQ-013 In IDLE with start=1, the block SHALL copy board into an internal snapshot, set anchor=0, clear winner/win_x/win_y/win_dir to 0, clear the empty_seen flag, and go to SCAN.
REQ-014 The scan SHALL use only the snapshot, so board changes during SCAN have no effect.
REQ-015 SCAN SHALL evaluate one anchor per cycle, with anchor index = y*16+x (x fastest), covering indices 0..255.
REQ-016 Per anchor, all four directions SHALL be checked in parallel; a direction hits when the anchor and the next 4 cells along it all equal the same value, and that value is 01 or 10.
REQ-017 Direction bounds SHALL be: E requires x<=11; S requires y<=11; SE requires x<=11 and y<=11; SW requires x>=4 and y<=11; an out-of-bounds direction never hits, so no run wraps across row edges.
REQ-018 When several directions hit at one anchor, priority SHALL be E > S > SE > SW; the lowest-index anchor with any hit wins the scan.
REQ-019 Runs longer than 5 SHALL count as wins, reported at their first in-scan-order anchor.
REQ-020 On a hit, the block SHALL register winner = the cell value together with x, y and dir, and go to DONE (early termination).
REQ-021 During SCAN, empty_seen SHALL be set if the anchor cell is 00 or 11.
REQ-022 If anchor 255 produces no hit, the block SHALL set winner=11 when empty_seen (including cell 255) is 0, otherwise winner=00 with x/y/dir=0, and go to DONE.
REQ-023 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-024 busy SHALL be high only in SCAN.
REQ-025 Latency: with start sampled at edge E0, a hit at anchor k SHALL pulse done in the cycle following edge E0+k+1; a full scan without a hit SHALL pulse done after edge E0+256.
REQ-026 The result outputs SHALL hold their values from done until the next accepted start.
REQ-027 start SHALL be ignored in SCAN and DONE, with no queuing.

Reset
REQ-028 When Reset=1 at a clock edge, the block SHALL enter IDLE and set busy=0, done=0, winner=00, win_x=0, win_y=0, win_dir=00, and anchor=0.
REQ-029 Reset SHALL take priority over start and over any scan in progress; an aborted scan SHALL never produce a done pulse.

Verification
REQ-030 Empty board, pulse start -> done 257 cycles later, winner=00, and busy high for 256 cycles.
REQ-031 Player 1 at (3..7, y=2) -> done 37 cycles after start, winner=01, win_x=3, win_y=2, win_dir=00.
REQ-032 Player 2 at (4,0),(3,1),(2,2),(1,3),(0,4) -> done 6 cycles after start, winner=10, win_x=4, win_y=0, win_dir=11.
REQ-033 Player 1 at x=12..15 on y=0 plus (0,1), which is contiguous in offset -> winner=00 (no wrap); the same pattern plus a player-1 vertical at x=9, y=5..9 -> winner=01, win_x=9, win_y=5, win_dir=01.
REQ-034 Full board with cell=01 if (x/2+y) is even, else 10 -> done at 257 cycles, winner=11.
REQ-035 Start a win-free scan, assert start again at cycle 10 (ignored), and change board at cycle 20 to contain a five (no effect) -> winner=00; then start a second scan, assert Reset at cycle 50 -> no done pulse and all outputs 0 on the next cycle.
